booth_dot_ctrl: RTL and testbench
=================================

# booth_dot_ctrl

Sequencing and accumulation stage that sits directly downstream of the 4-bit signed Booth multiplier (`booth_multi`). It accepts a stream of signed operand pairs over a valid/ready handshake and drives the multiplier's `start`/`A`/`B` inputs one pair at a time. For each pair it waits for `done`, then sign-extends and accumulates the 8-bit product. When the pair flagged `in_last` has been accumulated, it presents the dot-product result with a sticky overflow flag and a term count.

## Interface
- `ACC_W`, 12: accumulator/result width in bits, signed. Legal range 8..32.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand pair presented.
- `in_ready` output 1: block can accept a pair.
- `in_a` input 4: signed multiplicand.
- `in_b` input 4: signed multiplier operand.
- `in_last` input 1: this pair closes the current dot product.
- `mul_start` output 1: one-cycle start pulse to the multiplier.
- `mul_a` output 4: operand to multiplier `A`.
- `mul_b` output 4: operand to multiplier `B`.
- `mul_out` input 8: signed product from the multiplier.
- `mul_done` input 1: multiplier completion level.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer takes the result.
- `res_data` output ACC_W: signed accumulated sum.
- `res_ovf` output 1: a signed overflow occurred during this dot product.
- `res_count` output 8: number of terms accumulated, saturating at 255.

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE
  - `in_ready`=1.
  - On `in_valid & in_ready`: register `in_a`, `in_b` and `in_last`, then go to ISSUE.
- ISSUE
  - `mul_start`=1 for exactly one cycle, with `mul_a`/`mul_b` driven from the registered operands.
  - Go to WAIT unconditionally.
- WAIT
  - `mul_a`/`mul_b` stay stable and `mul_start`=0.
  - On `mul_done`=1:
    - `acc <= acc + sext(mul_out)`.
    - `res_count` increments, saturating at 255.
    - If the registered last flag is set, go to OUT; otherwise go to IDLE.
- OUT
  - `res_valid`=1, and `res_data`, `res_ovf`, `res_count` are held stable.
  - On `res_ready`: clear the accumulator, the overflow flag and the count, then go to IDLE.
- `mul_done` is ignored in every state except WAIT. It may be X or stale after reset, because the multiplier has no reset.
- Arithmetic:
  - The product is sign-extended from 8 to ACC_W bits and added modulo 2^ACC_W.
  - Signed overflow: both operands have the same sign and the sum has a different sign. It sets `res_ovf`, which stays set (sticky) until the result is consumed. The result wraps; it does not saturate.
- `in_ready` is 0 in ISSUE, WAIT and OUT. No operand buffering is done.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`=1.
  - `mul_start`=0, `mul_a`=0, `mul_b`=0.
  - `res_valid`=0, `res_data`=0, `res_ovf`=0, `res_count`=0.
- Because the multiplier samples `start` on the same edge that moves this block into WAIT, `mul_done` is already 0 in the first WAIT cycle.
- With `booth_multi` attached:
  - WAIT lasts 6 cycles (1 load edge plus 4 shift edges plus 1 done edge).
  - One term costs 8 cycles: IDLE 1 + ISSUE 1 + WAIT 6.
  - The RTL must not hard-code this count; it must key only on `mul_done`.
- `res_valid` rises in the cycle after the edge that accumulates the last term.
- The earliest next `in_ready` is the cycle after the `res_ready` handshake.
- Async reset mid-operation:
  - All outputs return to their reset values immediately.
  - Any multiplier activity in flight is discarded.
  - The next ISSUE restarts the multiplier, because `start` has priority there.
- `in_valid` held high in OUT: the pair is not accepted until the result has been consumed.

## Test plan
- Reset: hold `rst_n`=0 with `mul_done`=X. Required: all outputs at their reset values and no `mul_start` pulse; after release, `in_ready`=1.
- Single term: pair (3, -2) with `in_last`=1. Required:
  - Exactly one `mul_start` pulse, with `mul_a`=3 and `mul_b`=-2.
  - `res_valid` asserted 8 cycles after acceptance.
  - `res_data`=-6, `res_ovf`=0, `res_count`=1.
- Four-term extreme: four pairs (-8, -8), the last one flagged. Required: `res_data`=256, `res_ovf`=0, `res_count`=4, and `in_ready` low for exactly 7 of every 8 cycles.
- Overflow with ACC_W=8: pairs (-8, -8) then (-8, -8) with last. Required: `res_data`=-128 (0x80), `res_ovf`=1; the next dot product, (1, 1) with last, returns `res_data`=1 and `res_ovf`=0.
- Backpressure: hold `res_ready`=0 for 10 cycles while `in_valid`=1. Required: `res_*` stable, `in_ready`=0 and no `mul_start`; accepting the result then admits the pending pair on the following cycle.
- Reset mid-WAIT: pulse `rst_n` low during the 3rd WAIT cycle, then send (2, 2) with last. Required: `res_data`=4 and `res_count`=1, with no residue from the aborted term.

Source files
------------

// File: rtl/booth_dot_ctrl_if.sv
// Handshake and multiplier-side bundle for booth_dot_ctrl.
// The slave modport is the controller; master is whatever drives it (source, multiplier, sink).
interface booth_dot_ctrl_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;

  logic             mul_start;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic [7:0]       mul_out;
  logic             mul_done;

  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;
  logic [7:0]       res_count;

  modport master (
    output in_valid, in_a, in_b, in_last, mul_out, mul_done, res_ready,
    input  in_ready, mul_start, mul_a, mul_b, res_valid, res_data, res_ovf, res_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_out, mul_done, res_ready,
    output in_ready, mul_start, mul_a, mul_b, res_valid, res_data, res_ovf, res_count
  );
endinterface

// File: rtl/booth_dot_ctrl.sv
// Feeds operand pairs to booth_multi one at a time and accumulates products into a dot product.
// One term per multiplier completion; no operand buffering, so input stalls until the result is taken.
module booth_dot_ctrl #(
  parameter int ACC_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_dot_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                  state_q;
  logic                    in_ready_q;
  logic                    mul_start_q;
  logic                    res_valid_q;
  logic                    last_q;
  logic                    ovf_q;
  logic [3:0]              a_q;
  logic [3:0]              b_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [7:0]              cnt_q;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_d;
  logic                    ovf_d;
  logic [7:0]              cnt_d;

  // Overflow only when both addends share a sign and the wrapped sum does not.
  always_comb begin
    prod_ext = ACC_W'(signed'(bus.mul_out));
    acc_d    = acc_q + prod_ext;
    ovf_d    = ovf_q | ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                        (acc_d[ACC_W-1] != acc_q[ACC_W-1]));
    cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q         <= bus.in_a;
            b_q         <= bus.in_b;
            last_q      <= bus.in_last;
            in_ready_q  <= 1'b0;
            mul_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // mul_done is only trusted here; elsewhere it may be stale or unknown.
          if (bus.mul_done) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (last_q) begin
              res_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        OUT: begin
          if (bus.res_ready) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          mul_start_q <= 1'b0;
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.res_count = cnt_q;
endmodule

// File: tb/tb_booth_dot_ctrl.sv
// Bench for booth_dot_ctrl: two instances (ACC_W 12 and 8) share stimulus and a booth_multi timing model.
module tb_booth_dot_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_last = 1'b0;
  logic       res_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_dot_ctrl_if #(.ACC_W(12)) b12 ();
  booth_dot_ctrl_if #(.ACC_W(8))  b8 ();

  booth_dot_ctrl #(.ACC_W(12)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(b12.slave));
  booth_dot_ctrl #(.ACC_W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  // Multiplier model: no reset, done rises 5 edges after start is sampled (6 WAIT cycles).
  logic [2:0] m_cnt;
  logic       m_done;
  logic [7:0] m_prod;
  always @(posedge clk) begin
    if (b12.mul_start === 1'b1) begin
      m_cnt  <= 3'd0;
      m_done <= 1'b0;
      m_prod <= $signed({{4{b12.mul_a[3]}}, b12.mul_a}) * $signed({{4{b12.mul_b[3]}}, b12.mul_b});
    end else if (m_cnt != 3'd7) begin
      m_cnt <= m_cnt + 3'd1;
      if (m_cnt == 3'd4) m_done <= 1'b1;
    end
  end

  int         n_starts = 0;
  logic [3:0] st_a = '0;
  logic [3:0] st_b = '0;
  always @(posedge clk) begin
    if (b12.mul_start === 1'b1) begin
      n_starts <= n_starts + 1;
      st_a     <= b12.mul_a;
      st_b     <= b12.mul_b;
    end
  end

  assign b12.in_valid  = in_valid;
  assign b12.in_a      = in_a;
  assign b12.in_b      = in_b;
  assign b12.in_last   = in_last;
  assign b12.res_ready = res_ready;
  assign b12.mul_out   = m_prod;
  assign b12.mul_done  = m_done;
  assign b8.in_valid   = in_valid;
  assign b8.in_a       = in_a;
  assign b8.in_b       = in_b;
  assign b8.in_last    = in_last;
  assign b8.res_ready  = res_ready;
  assign b8.mul_out    = m_prod;
  assign b8.mul_done   = m_done;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Each term i of a vector uses nibble (i % len) of av/bv.
  typedef struct {
    int          n;
    int          len;
    logic [31:0] av;
    logic [31:0] bv;
    int          d12;
    int          o12;
    int          d8;
    int          o8;
    int          cnt;
  } vec_t;

  task automatic take_result(input string tag);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_rdy_after"}, int'(b12.in_ready), 1);
    chk({tag, "_cnt_clr"}, int'(b12.res_count), 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int sent = 0;
    int cyc = 0;
    int rdy = 0;
    int base = n_starts;
    int k;
    logic [3:0] ea;
    logic [3:0] eb;
    while (b12.res_valid !== 1'b1 && cyc < 8 * v.n + 50) begin
      if (b12.in_ready === 1'b1) begin
        if (sent < v.n) begin
          k        = sent % v.len;
          in_valid = 1'b1;
          in_a     = v.av[4*k +: 4];
          in_b     = v.bv[4*k +: 4];
          in_last  = (sent == v.n - 1);
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      cyc++;
      if (b12.in_ready === 1'b1) rdy++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    k  = (v.n - 1) % v.len;
    ea = v.av[4*k +: 4];
    eb = v.bv[4*k +: 4];
    chk({tag, "_latency"}, cyc, 8 * v.n);
    chk({tag, "_rdy_cycles"}, rdy, v.n);
    chk({tag, "_starts"}, n_starts - base, v.n);
    chk({tag, "_mul_a"}, int'($signed(st_a)), int'($signed(ea)));
    chk({tag, "_mul_b"}, int'($signed(st_b)), int'($signed(eb)));
    chk({tag, "_res12"}, int'($signed(b12.res_data)), v.d12);
    chk({tag, "_ovf12"}, int'(b12.res_ovf), v.o12);
    chk({tag, "_res8"}, int'($signed(b8.res_data)), v.d8);
    chk({tag, "_ovf8"}, int'(b8.res_ovf), v.o8);
    chk({tag, "_cnt12"}, int'(b12.res_count), v.cnt);
    chk({tag, "_cnt8"}, int'(b8.res_count), v.cnt);
    take_result(tag);
  endtask

  task automatic push(input string tag, input logic [3:0] a, input logic [3:0] b, input logic l);
    int g = 0;
    while (b12.in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_push_rdy"}, int'(b12.in_ready), 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int g = 0;
    while (b12.res_valid !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_res_vld"}, int'(b12.res_valid), 1);
  endtask

  vec_t vt[8];
  vec_t vr;

  initial begin
    int base;
    int bad;

    //        n    len  av            bv            d12    o12 d8    o8 cnt
    vt[0] = '{1,   1,   32'h0000_0003, 32'h0000_000E, -6,    0,  -6,   0, 1};
    vt[1] = '{4,   1,   32'h0000_0008, 32'h0000_0008, 256,   0,  0,    1, 4};
    vt[2] = '{2,   1,   32'h0000_0008, 32'h0000_0008, 128,   0,  -128, 1, 2};
    vt[3] = '{1,   1,   32'h0000_0001, 32'h0000_0001, 1,     0,  1,    0, 1};
    vt[4] = '{3,   3,   32'h0000_0787, 32'h0000_0877, -63,   0,  -63,  0, 3};
    vt[5] = '{3,   1,   32'h0000_0008, 32'h0000_0007, -168,  0,  88,   1, 3};
    vt[6] = '{32,  1,   32'h0000_0008, 32'h0000_0008, -2048, 1,  0,    1, 32};
    vt[7] = '{256, 1,   32'h0000_0001, 32'h0000_0001, 256,   0,  0,    1, 255};
    vr    = '{1,   1,   32'h0000_0002, 32'h0000_0002, 4,     0,  4,    0, 1};

    // Reset with the multiplier model still unknown.
    base = n_starts;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(b12.in_ready), 1);
    chk("rst_mul_start", int'(b12.mul_start), 0);
    chk("rst_mul_a", int'(b12.mul_a), 0);
    chk("rst_mul_b", int'(b12.mul_b), 0);
    chk("rst_res_valid", int'(b12.res_valid), 0);
    chk("rst_res_data", int'(b12.res_data), 0);
    chk("rst_res_ovf", int'(b12.res_ovf), 0);
    chk("rst_res_count", int'(b12.res_count), 0);
    chk("rst_no_start", n_starts - base, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(b12.in_ready), 1);

    for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vt[i]);

    // Backpressure: result held while a new pair waits.
    push("bp", 4'd2, 4'd3, 1'b1);
    wait_res("bp");
    in_valid = 1'b1;
    in_a     = 4'd1;
    in_b     = 4'hF;
    in_last  = 1'b1;
    base = n_starts;
    bad  = 0;
    repeat (10) begin
      @(negedge clk);
      if (b12.res_valid !== 1'b1 || $signed(b12.res_data) !== 12'sd6 || b12.res_ovf !== 1'b0 ||
          b12.res_count !== 8'd1 || b12.in_ready !== 1'b0 || b12.mul_start !== 1'b0) bad++;
    end
    chk("bp_hold_violations", bad, 0);
    chk("bp_no_start", n_starts - base, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_ready_next", int'(b12.in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_issue_start", int'(b12.mul_start), 1);
    chk("bp_issue_a", int'(b12.mul_a), 1);
    wait_res("bp2");
    chk("bp2_res12", int'($signed(b12.res_data)), -1);
    take_result("bp2");

    // Reset during the third WAIT cycle of a second term.
    push("rw1", 4'd7, 4'd7, 1'b0);
    push("rw2", 4'd7, 4'd7, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_in_ready", int'(b12.in_ready), 1);
    chk("rw_mul_start", int'(b12.mul_start), 0);
    chk("rw_mul_a", int'(b12.mul_a), 0);
    chk("rw_res_valid", int'(b12.res_valid), 0);
    chk("rw_res_data", int'(b12.res_data), 0);
    chk("rw_res_count", int'(b12.res_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("rw_after", vr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
